i2s_clk_ctrl: RTL and testbench
===============================

# i2s_clk_ctrl

Clock and frame controller for the bidirectional I2S block. It generates `sclk` and `lrclk` from the system clock using a programmable divider, with glitch-free start and stop on frame boundaries. It also serves the transmitter's per-frame sample requests from an upstream valid/ready stream, substituting silence and counting an underrun whenever the stream has no sample ready. It sits between the audio sample FIFO and the I2S tx/rx pair, and drives the shared bit and word clocks that both of them use.

## Interface
- `DW`, 24: sample width per channel.
- `SLOT`, 32: `sclk` periods per channel slot; must be ≥ `DW`.
- `DIV_W`, 8: width of the divider control.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, level-sensitive.
- `div`  in  DIV_W  `sclk` half-period in `clk` cycles, minus 1.
- `sclk`  out  1  I2S bit clock, registered.
- `lrclk`  out  1  I2S word clock; 0 = left, 1 = right; registered.
- `running`  out  1  high while in RUN or STOP.
- `frame_start`  out  1  one-cycle pulse when a frame begins.
- `s_ldata`, `s_rdata`  in  DW  upstream sample pair.
- `s_valid`  in  1  upstream sample pair is available.
- `s_ready`  out  1  combinational; equals `tx_rd_en & running`.
- `tx_ldata`, `tx_rdata`  out  DW  sample pair presented to the transmitter.
- `tx_rd_en`  in  1  one-cycle sample request from the transmitter.
- `tx_rd_valid`  out  1  one-cycle pulse: `tx_*data` is valid.
- `underrun_cnt`  out  16  saturating count of underruns.
- `clear`  in  1  synchronous clear of `underrun_cnt`.

## Operation
- **State IDLE.**
  - `sclk` = 0, `lrclk` = 0, counters are held at 0.
  - `enable` = 1 latches `div` into `div_q`, sets `hcnt` = 0 and `bcnt` = 0, and moves to RUN.
- **State RUN.**
  - `hcnt` counts 0..`div_q`. At terminal count, `sclk` toggles and `hcnt` returns to 0.
  - On each `sclk` falling toggle, `bcnt` advances 0..2·SLOT−1 and wraps.
  - `lrclk` is set to (`bcnt_next` ≥ SLOT) on the same falling toggle.
  - `enable` = 0 moves to STOP.
- **Frame boundary.**
  - Defined as the falling toggle on which `bcnt` wraps from 2·SLOT−1 to 0.
  - `frame_start` pulses in that cycle.
  - `div_q` reloads from `div` at the boundary; a divider change never takes effect mid-frame.
- **State STOP.**
  - Clocks continue until the next frame boundary, then go to IDLE with `sclk` = 0 and `lrclk` = 0.
  - `enable` reasserted during STOP returns to RUN immediately; no boundary event occurs.
- **Sample service.**
  - On `tx_rd_en` with `running` = 1 and `s_valid` = 1: transfer occurs (`s_ready` = 1). `s_ldata`/`s_rdata` are registered into `tx_ldata`/`tx_rdata`.
  - On `tx_rd_en` with `running` = 1 and `s_valid` = 0: this is an underrun. `tx_ldata` = `tx_rdata` = 0 and `underrun_cnt` increments, saturating at 0xFFFF.
  - In both cases `tx_rd_valid` pulses on the following cycle.
  - `tx_rd_en` while IDLE is ignored: no `s_ready`, no `tx_rd_valid`, no count.
- **Counter clear.** `clear` and an underrun in the same cycle: clear wins, result is 0.

## Timing
- Reset value of every output is 0.
- An asynchronous reset mid-frame forces IDLE immediately; a partial frame is acceptable.
- `sclk` period is 2·(`div_q`+1) `clk` cycles. `div` = 0 gives `sclk` = `clk`/2.
- A frame is 2·SLOT `sclk` periods, i.e. 4·SLOT·(`div_q`+1) `clk` cycles.
- Start latency: the first `sclk` rising edge occurs `div_q`+1 cycles after the cycle in which `enable` is sampled high in IDLE.
- `lrclk` changes only in cycles where `sclk` goes 1→0.
- Request-to-data latency is exactly 1 cycle. Back-to-back `tx_rd_en` in consecutive cycles must each be serviced.
- The sampling cycle for `div` is the IDLE→RUN transition or a frame-boundary cycle.
- `running` goes low in the same cycle that `sclk` returns to 0 at the final boundary.

## Test plan
- **Divider and frame timing.** `div` = 3, `SLOT` = 32, enable held → `sclk` period 8 clk; `lrclk` toggles every 256 clk; `frame_start` every 512 clk; first `sclk` rise 4 cycles after enable.
- **Sample transfer.** `s_valid` = 1 with `s_ldata` = 0x123456, `s_rdata` = 0xABCDEF, pulse `tx_rd_en` → `s_ready` = 1 in the same cycle; next cycle `tx_rd_valid` = 1 with those values; `underrun_cnt` stays 0.
- **Underrun.** `s_valid` = 0 for 3 requests → three `tx_rd_valid` pulses with zero data; `underrun_cnt` = 3. Then `clear` together with a 4th underrun → count = 0.
- **Saturation.** Preload by running 65 536 underrun requests → `underrun_cnt` = 0xFFFF; one more request keeps it at 0xFFFF.
- **Clean stop and divider change.** Drop `enable` at `bcnt` = 10 → clocks continue to the frame boundary, then `sclk` = `lrclk` = `running` = 0. Change `div` 3→1 mid-frame → the new period of 4 clk applies only from the next `frame_start`.
- **Reset mid-frame.** Assert `rst_n` = 0 mid-frame → all outputs 0 immediately. Release with `enable` = 1 → restart from `bcnt` = 0, `lrclk` = 0.

Source files
------------

// File: rtl/i2s_clk_ctrl.sv
// I2S bit/word clock generator with frame-aligned start/stop and transmitter
// sample service from an upstream valid/ready stream.
`timescale 1ns/1ps
module i2s_clk_ctrl #(
  parameter int DW    = 24,
  parameter int SLOT  = 32,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             lrclk,
  output logic             running,
  output logic             frame_start,
  input  logic [DW-1:0]    s_ldata,
  input  logic [DW-1:0]    s_rdata,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DW-1:0]    tx_ldata,
  output logic [DW-1:0]    tx_rdata,
  input  logic             tx_rd_en,
  output logic             tx_rd_valid,
  output logic [15:0]      underrun_cnt,
  input  logic             clear
);
  // state | meaning
  // IDLE  | clocks parked low, waiting for enable
  // RUN   | clocks running, enable held
  // STOP  | clocks running until the next frame boundary, then IDLE

  localparam int BW = $clog2(2 * SLOT);
  localparam logic [BW-1:0] BCNT_LAST = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] SLOT_B    = BW'(SLOT);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hcnt;
  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bcnt_next;
  logic             tc;
  logic             fall;
  logic             wrap;
  logic             req;

  // Half-period terminal count and the falling-edge / frame-wrap events it produces.
  always_comb begin
    tc        = (hcnt == div_q);
    fall      = tc & sclk;
    wrap      = fall & (bcnt == BCNT_LAST);
    bcnt_next = wrap ? '0 : bcnt + 1'b1;
  end

  // Clock/frame sequencer; all clock outputs registered so sclk/lrclk are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_q       <= '0;
      hcnt        <= '0;
      bcnt        <= '0;
      sclk        <= 1'b0;
      lrclk       <= 1'b0;
      running     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          sclk    <= 1'b0;
          lrclk   <= 1'b0;
          hcnt    <= '0;
          bcnt    <= '0;
          running <= 1'b0;
          if (enable) begin
            div_q   <= div;
            running <= 1'b1;
            state   <= RUN;
          end
        end
        RUN, STOP: begin
          if (tc) begin
            hcnt <= '0;
            sclk <= ~sclk;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
          if (fall) begin
            bcnt  <= bcnt_next;
            lrclk <= (bcnt_next >= SLOT_B);
          end
          if (wrap && (state == STOP) && !enable) begin
            // final boundary: park everything low in the same cycle
            sclk    <= 1'b0;
            lrclk   <= 1'b0;
            hcnt    <= '0;
            bcnt    <= '0;
            running <= 1'b0;
            state   <= IDLE;
          end else begin
            if (wrap) begin
              // divider changes only land on a frame boundary
              frame_start <= 1'b1;
              div_q       <= div;
            end
            state <= enable ? RUN : STOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req     = tx_rd_en & running;
  assign s_ready = req;

  // Sample service: transfer or substitute silence, one-cycle valid pulse after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ldata     <= '0;
      tx_rdata     <= '0;
      tx_rd_valid  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      tx_rd_valid <= req;
      if (req) begin
        if (s_valid) begin
          tx_ldata <= s_ldata;
          tx_rdata <= s_rdata;
        end else begin
          tx_ldata <= '0;
          tx_rdata <= '0;
        end
      end
      // clear takes priority over a coincident underrun
      if (clear) begin
        underrun_cnt <= '0;
      end else if (req && !s_valid && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Directed bench for i2s_clk_ctrl: clock/frame timing, sample service, stop, reset.
`timescale 1ns/1ps
module tb_i2s_clk_ctrl;
  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             sclk, lrclk, running, frame_start;
  logic [DW-1:0]    s_ldata = '0, s_rdata = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    tx_ldata, tx_rdata;
  logic             tx_rd_en = 1'b0;
  logic             tx_rd_valid;
  logic [15:0]      underrun_cnt;
  logic             clear = 1'b0;

  i2s_clk_ctrl #(.DW(DW), .SLOT(SLOT), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div(div),
    .sclk(sclk), .lrclk(lrclk), .running(running), .frame_start(frame_start),
    .s_ldata(s_ldata), .s_rdata(s_rdata), .s_valid(s_valid), .s_ready(s_ready),
    .tx_ldata(tx_ldata), .tx_rdata(tx_rdata), .tx_rd_en(tx_rd_en),
    .tx_rd_valid(tx_rd_valid), .underrun_cnt(underrun_cnt), .clear(clear)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [15:0] m_cnt = 16'h0;

  int cyc = 0, last_rise = 0, prev_rise = 0, last_lr = 0, prev_lr = 0;
  int last_fs = 0, prev_fs = 0, falls_since_fs = 0, lr_bad = 0;
  logic sclk_d = 1'b0, lr_d = 1'b0;

  // Edge/pulse timestamp monitor, sampled shortly after each rising clk edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (sclk && !sclk_d) begin prev_rise = last_rise; last_rise = cyc; end
    if (!sclk && sclk_d) falls_since_fs++;
    if (lrclk !== lr_d) begin
      prev_lr = last_lr; last_lr = cyc;
      if (rst_n && !(sclk_d && !sclk)) lr_bad++;
    end
    if (frame_start) begin prev_fs = last_fs; last_fs = cyc; falls_since_fs = 0; end
    sclk_d = sclk;
    lr_d   = lrclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    tx_rd_en = 1'b0; s_valid = 1'b0; clear = 1'b0;
  endtask

  // Drive one request at a negedge; expected data goes to the scoreboard.
  task automatic issue(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input bit clr, input bit exp_run);
    tx_rd_en = 1'b1; s_valid = v; s_ldata = l; s_rdata = r; clear = clr;
    #1;
    chk("s_ready", 64'(s_ready), 64'(exp_run));
    if (exp_run) exp_q.push_back(v ? {l, r} : '0);
    if (clr) m_cnt = 16'h0;
    else if (exp_run && !v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    @(negedge clk);
  endtask

  task automatic collect(input bit exp_valid);
    logic [2*DW-1:0] e;
    chk("tx_rd_valid", 64'(tx_rd_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 64'({tx_ldata, tx_rdata}), 64'(e));
      end
    end
    chk("underrun_cnt", 64'(underrun_cnt), 64'(m_cnt));
  endtask

  task automatic wait_fs(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    chk("frame_start_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_rise(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (sclk) seen = 1'b1;
      else @(negedge clk);
    end
    chk("sclk_rise_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    int e0, fs_ref;
    bit stopped;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_outputs", 64'({sclk, lrclk, running, frame_start, tx_rd_valid, s_ready}), 64'd0);
    chk("rst_data", 64'({tx_ldata, tx_rdata}), 64'd0);
    chk("rst_cnt", 64'(underrun_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_running", 64'(running), 64'd0);

    // divider and frame timing, div = 3
    div = 8'd3; enable = 1'b1;
    @(negedge clk); e0 = cyc;
    wait_rise(20);
    chk("first_rise_latency", 64'(last_rise - e0), 64'd4);
    wait_fs(600);
    chk("first_frame_start", 64'(last_fs - e0), 64'd512);
    chk("lrclk_to_right", 64'(prev_lr - e0), 64'd256);
    chk("lrclk_to_left", 64'(last_lr - e0), 64'd512);
    chk("sclk_period_div3", 64'(last_rise - prev_rise), 64'd8);
    wait_fs(600);
    chk("frame_period_div3", 64'(last_fs - prev_fs), 64'd512);

    // sample transfer
    issue(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b1);
    collect(1'b1);
    idle_in();
    @(negedge clk);
    collect(1'b0);

    // back-to-back underruns, then clear with a coincident underrun
    issue(1'b0, 24'h111111, 24'h222222, 1'b0, 1'b1); collect(1'b1);
    issue(1'b0, 24'h333333, 24'h444444, 1'b0, 1'b1); collect(1'b1);
    issue(1'b0, 24'h555555, 24'h666666, 1'b0, 1'b1); collect(1'b1);
    chk("underrun_three", 64'(underrun_cnt), 64'd3);
    issue(1'b0, 24'h777777, 24'h888888, 1'b1, 1'b1); collect(1'b1);
    chk("clear_wins", 64'(underrun_cnt), 64'd0);
    idle_in();

    // divider change mid-frame applies from the next frame only
    wait_fs(600);
    repeat (20) @(negedge clk);
    div = 8'd1;
    repeat (20) @(negedge clk);
    chk("sclk_period_old_div", 64'(last_rise - prev_rise), 64'd8);
    wait_fs(600);
    chk("frame_len_old_div", 64'(last_fs - prev_fs), 64'd512);
    repeat (20) @(negedge clk);
    chk("sclk_period_new_div", 64'(last_rise - prev_rise), 64'd4);
    wait_fs(600);
    chk("frame_len_new_div", 64'(last_fs - prev_fs), 64'd256);

    // clean stop requested at bcnt = 10
    for (int i = 0; i < 400 && falls_since_fs != 10; i++) @(negedge clk);
    chk("bcnt_reached_10", 64'(falls_since_fs), 64'd10);
    enable = 1'b0;
    fs_ref = last_fs;
    stopped = 1'b0;
    for (int i = 0; i < 600 && !stopped; i++) begin
      @(negedge clk);
      if (!running) stopped = 1'b1;
    end
    chk("stop_reached", 64'(stopped), 64'd1);
    chk("stop_at_boundary", 64'(cyc - fs_ref), 64'd256);
    chk("stop_clocks_low", 64'({sclk, lrclk}), 64'd0);
    chk("lrclk_only_on_sclk_fall", 64'(lr_bad), 64'd0);

    // requests while idle are ignored
    issue(1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
    collect(1'b0);
    idle_in();

    // restart, make state nonzero, then reset mid-frame
    enable = 1'b1;
    repeat (30) @(negedge clk);
    issue(1'b0, 24'h0, 24'h0, 1'b0, 1'b1); collect(1'b1);
    issue(1'b1, 24'h5A5A5A, 24'hC3C3C3, 1'b0, 1'b1); collect(1'b1);
    idle_in();
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({sclk, lrclk, running, frame_start, tx_rd_valid, s_ready}), 64'd0);
    chk("async_rst_data", 64'({tx_ldata, tx_rdata}), 64'd0);
    chk("async_rst_cnt", 64'(underrun_cnt), 64'd0);
    m_cnt = 16'h0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); e0 = cyc;
    chk("restart_running", 64'(running), 64'd1);
    chk("restart_lrclk", 64'(lrclk), 64'd0);
    wait_rise(20);
    chk("restart_first_rise", 64'(last_rise - e0), 64'd2);

    // enable dropped briefly in STOP: clocks keep frame timing
    repeat (50) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_fs(400);
    chk("restart_frame_start", 64'(last_fs - e0), 64'd256);
    chk("reenable_running", 64'(running), 64'd1);

    // saturation: 65536 back-to-back underruns
    s_valid = 1'b0; tx_rd_en = 1'b1;
    repeat (65536) @(negedge clk);
    chk("saturate_ffff", 64'(underrun_cnt), 64'hFFFF);
    chk("saturate_valid", 64'(tx_rd_valid), 64'd1);
    @(negedge clk);
    chk("saturate_hold", 64'(underrun_cnt), 64'hFFFF);
    tx_rd_en = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_after_sat", 64'(underrun_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
